ex_issue_rx: RTL and testbench

- Receiving end of the ID→EX issue interface.
- The ID/EX pipeline register presents unit/val/tag/op/target and announces each new instruction by toggling ce. There is no valid level and no backpressure on that link.
- This block detects each ce toggle, captures the instruction into a small FIFO, and dispatches the head entry to the selected execution unit over a per-unit valid/ready handshake.
- It raises an almost-full stall to ID so toggles are never lost in normal operation.

---
 rtl/ex_issue_rx_if.sv | 40 ++++
 rtl/ex_issue_rx.sv | 114 +++++++++++
 tb/tb_ex_issue_rx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_issue_rx_if.sv
// ID->EX issue link: toggle-strobed instruction input, per-unit valid/ready dispatch
// and status back to ID. The slave side is the issue receiver.
interface ex_issue_rx_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int TGT_W  = 5,
    parameter int UNIT_N = 4,
    parameter int DEPTH  = 4
);
    localparam int UNIT_W = $clog2(UNIT_N);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              in_ce;
    logic [UNIT_W-1:0] in_unit;
    logic [DATA_W-1:0] in_val;
    logic [TAG_W-1:0]  in_tag;
    logic [OP_W-1:0]   in_op;
    logic [TGT_W-1:0]  in_target;
    logic              flush;
    logic              stall;
    logic [UNIT_N-1:0] iss_valid;
    logic [UNIT_N-1:0] iss_ready;
    logic [DATA_W-1:0] iss_val;
    logic [TAG_W-1:0]  iss_tag;
    logic [OP_W-1:0]   iss_op;
    logic [TGT_W-1:0]  iss_target;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output in_ce, in_unit, in_val, in_tag, in_op, in_target, flush, iss_ready,
        input  stall, iss_valid, iss_val, iss_tag, iss_op, iss_target, count, overflow
    );

    modport slave (
        input  in_ce, in_unit, in_val, in_tag, in_op, in_target, flush, iss_ready,
        output stall, iss_valid, iss_val, iss_tag, iss_op, iss_target, count, overflow
    );
endinterface

// File: rtl/ex_issue_rx.sv
// Issue receiver: turns ce toggles into FIFO pushes and dispatches the head entry
// in order to the selected execution unit over valid/ready.
module ex_issue_rx #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int TGT_W  = 5,
    parameter int UNIT_N = 4,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    ex_issue_rx_if.slave    bus
);
    localparam int UNIT_W = $clog2(UNIT_N);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [UNIT_W-1:0] unit;
        logic [DATA_W-1:0] val;
        logic [TAG_W-1:0]  tag;
        logic [OP_W-1:0]   op;
        logic [TGT_W-1:0]  target;
    } entry_t;

    entry_t            mem_r [DEPTH];
    logic              ce_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    logic              new_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [UNIT_N-1:0] sel_s;
    entry_t            head_s;
    entry_t            wr_s;

    // Toggle detection, head selection and push/pop/drop decisions
    always_comb begin
        new_s  = bus.in_ce ^ ce_r;
        full_s = (count_r == CNT_W'(DEPTH));
        head_s = mem_r[head_r];
        if (count_r != {CNT_W{1'b0}}) begin
            sel_s = UNIT_N'(1) << head_s.unit;
        end else begin
            sel_s = {UNIT_N{1'b0}};
        end
        pop_s  = |(sel_s & bus.iss_ready);
        // A same-edge pop frees the slot, so a full FIFO can still accept the toggle
        push_s = new_s & ~bus.flush & (~full_s | pop_s);
        drop_s = new_s & ~bus.flush & full_s & ~pop_s;
    end

    assign wr_s = '{unit:   bus.in_unit,
                    val:    bus.in_val,
                    tag:    bus.in_tag,
                    op:     bus.in_op,
                    target: bus.in_target};

    // Pointer, occupancy, edge-detect and sticky overflow state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_r       <= 1'b0;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            ce_r <= bus.in_ce;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (bus.flush) begin
                head_r  <= {PTR_W{1'b0}};
                tail_r  <= {PTR_W{1'b0}};
                count_r <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    tail_r <= tail_r + PTR_W'(1);
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Payload storage; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= wr_s;
        end
    end

    assign bus.iss_valid  = sel_s;
    assign bus.iss_val    = head_s.val;
    assign bus.iss_tag    = head_s.tag;
    assign bus.iss_op     = head_s.op;
    assign bus.iss_target = head_s.target;
    assign bus.count      = count_r;
    assign bus.overflow   = overflow_r;
    assign bus.stall      = (CNT_W'(DEPTH) - count_r) <= CNT_W'(1);

endmodule

// File: tb/tb_ex_issue_rx.sv
// Directed and randomized bench for ex_issue_rx against a queue-based reference model.
module tb_ex_issue_rx;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_issue_rx_if bus ();
    ex_issue_rx dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  unit;
        logic [31:0] val;
        logic [3:0]  tag;
        logic [5:0]  op;
        logic [4:0]  tgt;
    } ent_t;

    ent_t q[$];
    logic m_ce;
    logic m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic [3:0] ev;
        ev = 4'd0;
        if (q.size() != 0) ev = 4'd1 << q[0].unit;
        chk("count", 64'(bus.count), 64'(q.size()));
        chk("stall", 64'(bus.stall), 64'((DEPTH - q.size()) <= 1));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("iss_valid", 64'(bus.iss_valid), 64'(ev));
        if (q.size() != 0) begin
            chk("iss_val", 64'(bus.iss_val), 64'(q[0].val));
            chk("iss_tag", 64'(bus.iss_tag), 64'(q[0].tag));
            chk("iss_op", 64'(bus.iss_op), 64'(q[0].op));
            chk("iss_target", 64'(bus.iss_target), 64'(q[0].tgt));
        end
    endtask

    // Apply one clock edge to the model using the current inputs, then check the DUT
    task automatic tick();
        ent_t e;
        bit   nw;
        bit   pop;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_ce  = 1'b0;
        end else begin
            nw  = (bus.in_ce != m_ce);
            pop = (q.size() != 0) && bus.iss_ready[q[0].unit];
            if (bus.flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (nw) begin
                    e = '{unit: bus.in_unit, val: bus.in_val, tag: bus.in_tag,
                          op: bus.in_op, tgt: bus.in_target};
                    if (q.size() < DEPTH) q.push_back(e);
                    else m_ovf = 1'b1;
                end
            end
            m_ce = bus.in_ce;
        end
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic push_in(input int unit, input logic [31:0] val, input int tag);
        bus.in_unit   = 2'(unit);
        bus.in_val    = val;
        bus.in_tag    = 4'(tag);
        bus.in_op     = 6'($urandom);
        bus.in_target = 5'($urandom);
        bus.in_ce     = ~bus.in_ce;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_ce     = 1'b0;
        bus.flush     = 1'b0;
        bus.iss_ready = 4'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.iss_ready = 4'hF;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("drain_empty", 64'(bus.count), 64'd0);
        bus.iss_ready = 4'h0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_ce     = 1'b0;
        bus.in_unit   = 2'd0;
        bus.in_val    = 32'd0;
        bus.in_tag    = 4'd0;
        bus.in_op     = 6'd0;
        bus.in_target = 5'd0;
        bus.flush     = 1'b0;
        bus.iss_ready = 4'h0;
        m_ce          = 1'b0;
        m_ovf         = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_valid", 64'(bus.iss_valid), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);

        // Single issue with one-cycle capture latency and no bypass
        push_in(2, 32'hDEADBEEF, 3);
        #1;
        chk("no_bypass", 64'(bus.iss_valid), 64'd0);
        tick();
        chk("single_valid", 64'(bus.iss_valid), 64'h4);
        chk("single_val", 64'(bus.iss_val), 64'hDEADBEEF);
        chk("single_tag", 64'(bus.iss_tag), 64'd3);
        bus.iss_ready = 4'b0100;
        tick();
        chk("single_pop_cnt", 64'(bus.count), 64'd0);
        chk("single_pop_vld", 64'(bus.iss_valid), 64'd0);
        bus.iss_ready = 4'h0;

        // Back-to-back fill, stall threshold, overflow drop, in-order drain
        for (int i = 1; i <= 4; i++) begin
            push_in(i % 4, 32'(i * 17), i);
            tick();
            chk("fill_stall", 64'(bus.stall), 64'(i >= 3));
        end
        chk("fill_count", 64'(bus.count), 64'd4);
        push_in(0, 32'h5555, 5);
        tick();
        chk("ovf_set", 64'(bus.overflow), 64'd1);
        chk("ovf_count", 64'(bus.count), 64'd4);
        bus.iss_ready = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 64'(bus.iss_tag), 64'(i));
            tick();
        end
        chk("drain_count", 64'(bus.count), 64'd0);
        chk("ovf_sticky", 64'(bus.overflow), 64'd1);
        bus.iss_ready = 4'h0;

        // Full FIFO with same-edge pop and push
        do_reset();
        for (int i = 6; i <= 9; i++) begin
            push_in(i % 4, 32'(i), i);
            tick();
        end
        bus.iss_ready = 4'b0100;
        push_in(1, 32'hA0A0, 10);
        tick();
        chk("pp_count", 64'(bus.count), 64'd4);
        chk("pp_ovf", 64'(bus.overflow), 64'd0);
        bus.iss_ready = 4'hF;
        for (int i = 7; i <= 10; i++) begin
            chk("pp_order", 64'(bus.iss_tag), 64'(i));
            tick();
        end
        bus.iss_ready = 4'h0;

        // Ready on non-selected units must not pop
        push_in(1, 32'h1111, 11);
        tick();
        push_in(3, 32'h3333, 12);
        tick();
        bus.iss_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wrong_unit_vld", 64'(bus.iss_valid), 64'b0010);
            chk("wrong_unit_val", 64'(bus.iss_val), 64'h1111);
        end
        bus.iss_ready = 4'b0010;
        tick();
        chk("right_unit_cnt", 64'(bus.count), 64'd1);
        chk("right_unit_tag", 64'(bus.iss_tag), 64'd12);
        drain();

        // Flush together with a toggle discards everything
        for (int i = 0; i < 3; i++) begin
            push_in(i, 32'(100 + i), i);
            tick();
        end
        bus.flush = 1'b1;
        push_in(3, 32'hBAD, 15);
        tick();
        bus.flush = 1'b0;
        chk("flush_cnt", 64'(bus.count), 64'd0);
        chk("flush_vld", 64'(bus.iss_valid), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("flush_no_phantom", 64'(bus.count), 64'd0);

        // Async reset while popping, with overflow already set
        for (int i = 0; i < 5; i++) begin
            push_in(2, 32'(200 + i), i);
            tick();
        end
        chk("pre_rst_ovf", 64'(bus.overflow), 64'd1);
        bus.iss_ready = 4'b0100;
        tick();
        #2;
        rst       = 1'b1;
        bus.in_ce = 1'b0;
        #1;
        chk("arst_vld", 64'(bus.iss_valid), 64'd0);
        chk("arst_cnt", 64'(bus.count), 64'd0);
        chk("arst_ovf", 64'(bus.overflow), 64'd0);
        bus.iss_ready = 4'h0;
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.iss_ready = 4'($urandom);
            bus.flush     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 6) push_in($urandom_range(0, 3), $urandom, $urandom_range(0, 15));
            tick();
        end
        bus.flush = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
